// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_stage
// Brief    : Program counter and IF/ID register with a RUN/HALTED fetch FSM.
// Revision : 1.0
// ============================================================================
module pc_fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         INSTR_W  = 16,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [7:0]         branch_target,
  output logic [7:0]         imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [7:0]         PC_out,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic               halted
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t              r_state;
  logic [7:0]          r_pc;
  logic [7:0]          r_pc_out;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_valid;
  logic                w_is_halt;

  assign w_is_halt = (imem_data[INSTR_W-1 -: 4] == HALT_OP);

  // Priority: reset, branch flush, stall, halted hold, normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_state  <= ST_RUN;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= 8'h00;
    end else if (branch_taken) begin
      r_pc    <= branch_target;
      r_valid <= 1'b0;
      r_state <= ST_RUN;
    end else if (stall) begin
      r_pc    <= r_pc;
    end else if (r_state == ST_HALTED) begin
      r_valid <= 1'b0;
    end else begin
      r_instr  <= imem_data;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
      // The halt word is delivered downstream but the PC parks on it.
      if (w_is_halt) begin
        r_state <= ST_HALTED;
      end else begin
        r_pc <= r_pc + 8'd1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign PC_out    = r_pc_out;
  assign if_instr  = r_instr;
  assign if_valid  = r_valid;
  assign halted    = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_stage
// Brief    : Directed vector table plus randomized run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  PC_out;
  logic [15:0] if_instr;
  logic        if_valid;
  logic        halted;

  logic [15:0] mem [256];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(8'h00), .INSTR_W(16), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .PC_out(PC_out), .if_instr(if_instr), .if_valid(if_valid), .halted(halted)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [7:0]  tgt;
    logic [7:0]  e_addr, e_pco;
    logic [15:0] e_instr;
    logic        e_v, e_h;
  } vec_t;

  vec_t tbl [32];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_pc, m_pco;
  logic [15:0] m_instr;
  logic        m_v, m_h;

  function automatic vec_t mk(input logic r, s, b, input logic [7:0] t,
                              input logic [7:0] a, p, input logic [15:0] ins,
                              input logic v, h);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t;
    x.e_addr = a; x.e_pco = p; x.e_instr = ins; x.e_v = v; x.e_h = h;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] a, p,
                           input logic [15:0] ins, input logic v, h);
    check({tag, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, a});
    check({tag, ".PC_out"},    {24'h0, PC_out},    {24'h0, p});
    check({tag, ".if_instr"},  {16'h0, if_instr},  {16'h0, ins});
    check({tag, ".if_valid"},  {31'h0, if_valid},  {31'h0, v});
    check({tag, ".halted"},    {31'h0, halted},    {31'h0, h});
  endtask

  // Model of one rising edge, written directly from the stage's priority rules.
  task automatic model_step(input logic r, s, b, input logic [7:0] t);
    logic [15:0] word;
    if (r) begin
      m_pc = 8'h00; m_h = 1'b0; m_v = 1'b0; m_instr = 16'h0; m_pco = 8'h00;
    end else if (b) begin
      m_pc = t; m_v = 1'b0; m_h = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (m_h) begin
      m_v = 1'b0;
    end else begin
      word    = mem[m_pc];
      m_instr = word;
      m_pco   = m_pc;
      m_v     = 1'b1;
      if (word[15:12] == 4'hF) m_h = 1'b1;
      else                     m_pc = 8'((int'(m_pc) + 1) % 256);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'h00, 8'(i)};
    mem[5] = 16'hF005;

    tbl[0]  = mk(1,0,0,8'h00, 8'h00,8'h00,16'h0000,0,0);
    tbl[1]  = mk(0,0,0,8'h00, 8'h01,8'h00,16'h0000,1,0);
    tbl[2]  = mk(0,0,0,8'h00, 8'h02,8'h01,16'h0001,1,0);
    tbl[3]  = mk(0,0,0,8'h00, 8'h03,8'h02,16'h0002,1,0);
    tbl[4]  = mk(0,0,0,8'h00, 8'h04,8'h03,16'h0003,1,0);
    tbl[5]  = mk(0,0,0,8'h00, 8'h05,8'h04,16'h0004,1,0);
    tbl[6]  = mk(0,0,0,8'h00, 8'h05,8'h05,16'hF005,1,1);
    tbl[7]  = mk(0,0,0,8'h00, 8'h05,8'h05,16'hF005,0,1);
    tbl[8]  = mk(0,1,0,8'h00, 8'h05,8'h05,16'hF005,0,1);
    tbl[9]  = mk(0,0,1,8'h40, 8'h40,8'h05,16'hF005,0,0);
    tbl[10] = mk(0,0,0,8'h00, 8'h41,8'h40,16'h0040,1,0);
    tbl[11] = mk(0,0,1,8'h10, 8'h10,8'h40,16'h0040,0,0);
    tbl[12] = mk(0,1,0,8'h00, 8'h10,8'h40,16'h0040,0,0);
    tbl[13] = mk(0,1,0,8'h00, 8'h10,8'h40,16'h0040,0,0);
    tbl[14] = mk(0,0,0,8'h00, 8'h11,8'h10,16'h0010,1,0);
    tbl[15] = mk(0,0,1,8'h20, 8'h20,8'h10,16'h0010,0,0);
    tbl[16] = mk(0,0,0,8'h00, 8'h21,8'h20,16'h0020,1,0);
    tbl[17] = mk(0,1,1,8'h80, 8'h80,8'h20,16'h0020,0,0);
    tbl[18] = mk(0,0,0,8'h00, 8'h81,8'h80,16'h0080,1,0);
    tbl[19] = mk(0,0,1,8'hFE, 8'hFE,8'h80,16'h0080,0,0);
    tbl[20] = mk(0,0,0,8'h00, 8'hFF,8'hFE,16'h00FE,1,0);
    tbl[21] = mk(0,0,0,8'h00, 8'h00,8'hFF,16'h00FF,1,0);
    tbl[22] = mk(0,0,0,8'h00, 8'h01,8'h00,16'h0000,1,0);
    tbl[23] = mk(0,0,1,8'h05, 8'h05,8'h00,16'h0000,0,0);
    tbl[24] = mk(0,0,0,8'h00, 8'h05,8'h05,16'hF005,1,1);
    tbl[25] = mk(1,1,0,8'h00, 8'h00,8'h00,16'h0000,0,0);
    tbl[26] = mk(0,0,0,8'h00, 8'h01,8'h00,16'h0000,1,0);
    tbl[27] = mk(0,0,1,8'h04, 8'h04,8'h00,16'h0000,0,0);
    tbl[28] = mk(0,0,0,8'h00, 8'h05,8'h04,16'h0004,1,0);
    tbl[29] = mk(0,1,0,8'h00, 8'h05,8'h04,16'h0004,1,0);
    tbl[30] = mk(0,0,1,8'h30, 8'h30,8'h04,16'h0004,0,0);
    tbl[31] = mk(0,0,0,8'h00, 8'h31,8'h30,16'h0030,1,0);

    for (int i = 0; i < 32; i++) begin
      rst = tbl[i].rst; stall = tbl[i].stall;
      branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_pco,
                tbl[i].e_instr, tbl[i].e_v, tbl[i].e_h);
    end

    // Randomized phase: random memory contents (some halt opcodes) and controls.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    m_pc = 8'h00; m_pco = 8'h00; m_instr = 16'h0; m_v = 1'b0; m_h = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst           = (c == 0) || ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = 8'($urandom);
      model_step(rst, stall, branch_taken, branch_target);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", c), m_pc, m_pco, m_instr, m_v, m_h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
